// File: rtl/ntt_bank_ctrl.sv
// Radix-2 in-place NTT stage sequencer for one coefficient bank.
// Latency: first read 1 cycle after start is accepted; write-back LAT+1 cycles after its read; done at 1+AW*(2**AW+LAT+1).
// No backpressure: issues one read per cycle, drains the write pipe between stages. Option macro: NTT_CTRL_INVERSE_EN (adds inv port).
module ntt_bank_ctrl #(
    parameter int AW  = 7,
    parameter int LAT = 4,
    parameter int SW  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
`ifdef NTT_CTRL_INVERSE_EN
    input  logic          inv,
`endif
    output logic          busy,
    output logic          done,
    output logic          ien,
    output logic          iren,
    output logic [AW-1:0] ra,
    output logic          iwen,
    output logic [AW-1:0] wa,
    output logic          bf_valid,
    output logic          bf_sel,
    output logic [SW-1:0] stage,
    output logic [AW-2:0] tw_idx
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [AW-1:0] CNT_LAST   = {AW{1'b1}};
    localparam logic [AW-1:0] DRAIN_LAST = AW'(LAT);
    localparam logic [SW-1:0] STG_LAST   = SW'(AW-1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] stg_q, stg_d;
    logic          inv_q;

    // Registered outputs: everything the bank sees comes straight from a flop.
    logic          iren_q, iren_d;
    logic [AW-1:0] ra_q, ra_d;
    logic          sel_q, sel_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [AW-2:0] tw_q, tw_d;
    logic          bfv_q, bfs_q;
    logic [AW:0]   wpipe_q [LAT+1];

    // Butterfly address generation from the read counter: cnt = {pair, a/b select}.
    logic [AW-1:0] pair_w, half, hmask, k_w, a_w, addr_c, tw_full;
    logic [SW-1:0] h_sh, tw_sh;
    logic          sel_c;

`ifdef NTT_CTRL_INVERSE_EN
    // Inverse runs spans smallest-first; the twiddle stride shrinks as spans grow.
    always_ff @(posedge clk) begin
        if (rst)                            inv_q <= 1'b0;
        else if (state_q == S_IDLE && start) inv_q <= inv;
    end
`else
    assign inv_q = 1'b0;
`endif

    // Span and twiddle shift amounts for the current stage and direction.
    always_comb begin
        h_sh  = STG_LAST - stg_q;
        tw_sh = stg_q;
        if (inv_q) begin
            h_sh  = stg_q;
            tw_sh = STG_LAST - stg_q;
        end
    end

    // a = g*2h + k, b = a + h, with h a power of two so div/mod become masks.
    always_comb begin
        sel_c   = cnt_q[0];
        pair_w  = {1'b0, cnt_q[AW-1:1]};
        half    = AW'(1) << h_sh;
        hmask   = half - AW'(1);
        k_w     = pair_w & hmask;
        a_w     = ((pair_w & ~hmask) << 1) | k_w;
        addr_c  = sel_c ? (a_w | half) : a_w;
        tw_full = k_w << tw_sh;
    end

    // FSM state and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
        end
    end

    // Next state plus the values the output flops will present next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
        iren_d  = 1'b0;
        ra_d    = '0;
        sel_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        stage_d = '0;
        tw_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    stg_d   = '0;
                end
            end
            S_RUN: begin
                busy_d  = 1'b1;
                iren_d  = 1'b1;
                ra_d    = addr_c;
                sel_d   = sel_c;
                stage_d = stg_q;
                tw_d    = tw_full[AW-2:0];
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_DRAIN: begin
                // Stage barrier: wait for the last write-back before the next stage reads.
                busy_d  = 1'b1;
                stage_d = stg_q;
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d = '0;
                    if (stg_q == STG_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        stg_d   = stg_q + SW'(1);
                        state_d = S_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output registers; bf_valid/bf_sel lag the read by one cycle to meet registered bank Q.
    always_ff @(posedge clk) begin
        if (rst) begin
            iren_q  <= 1'b0;
            ra_q    <= '0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            stage_q <= '0;
            tw_q    <= '0;
            bfv_q   <= 1'b0;
            bfs_q   <= 1'b0;
        end else begin
            iren_q  <= iren_d;
            ra_q    <= ra_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            stage_q <= stage_d;
            tw_q    <= tw_d;
            bfv_q   <= iren_q;
            bfs_q   <= sel_q;
        end
    end

    // Write-back pipe: the read strobe and address re-emerge LAT+1 cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= LAT; i++) wpipe_q[i] <= '0;
        end else begin
            wpipe_q[0] <= {iren_q, ra_q};
            for (int i = 1; i <= LAT; i++) wpipe_q[i] <= wpipe_q[i-1];
        end
    end

    assign iren     = iren_q;
    assign ra       = ra_q;
    assign iwen     = wpipe_q[LAT][AW];
    assign wa       = wpipe_q[LAT][AW-1:0];
    assign ien      = iren_q | wpipe_q[LAT][AW];
    assign busy     = busy_q;
    assign done     = done_q;
    assign bf_valid = bfv_q;
    assign bf_sel   = bfs_q;
    assign stage    = stage_q;
    assign tw_idx   = tw_q;

endmodule
